// File: rtl/logic_pkg.sv
// Shared constants and types for the bitwise logic sequencing front-end.
package logic_pkg;

  localparam int W  = 32;
  localparam int RW = 67;
  localparam int CW = 16;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_ctrl_units.sv
// Bitwise logic units shared with the ALU; purely combinational, one per function.
module and_op #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a & b;
endmodule

module or_op #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a | b;
endmodule

module xor_op #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/logic_op_ctrl.sv
// Accepts one logic-op request, runs all three units on latched operands and
// holds the zero-extended result plus flags until the consumer takes it.
module logic_op_ctrl #(
  parameter int W  = logic_pkg::W,
  parameter int RW = logic_pkg::RW,
  parameter int CW = logic_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] result,
  output logic          zero,
  output logic          neg,
  output logic          err,
  output logic [CW-1:0] op_cnt
);
  import logic_pkg::*;

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  and_y, or_y, xor_y, sel;
  logic [W-1:0]  res_q;
  logic          zero_q, neg_q, err_q;
  logic [CW-1:0] cnt_q;

  and_op #(.W(W)) u_and (.a(a_q), .b(b_q), .y(and_y));
  or_op  #(.W(W)) u_or  (.a(a_q), .b(b_q), .y(or_y));
  xor_op #(.W(W)) u_xor (.a(a_q), .b(b_q), .y(xor_y));

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
  end

  // Illegal opcode selects zero, which yields zero=1 and neg=0 for free.
  always_comb begin
    sel = '0;
    case (op_q)
      OP_AND:  sel = and_y;
      OP_OR:   sel = or_y;
      OP_XOR:  sel = xor_y;
      default: sel = '0;
    endcase
  end

  // NOTE: operand latches are reset too, so the units never see X after reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      op_q   <= OP_AND;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
        end
        EXEC: begin
          res_q  <= sel;
          zero_q <= (sel == '0);
          neg_q  <= sel[W-1];
          err_q  <= (op_q == OP_ILL);
        end
        HOLD: if (out_ready) cnt_q <= cnt_q + CW'(1);
        default: ;
      endcase
    end
  end

  assign result = {{(RW-W){1'b0}}, res_q};
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign err    = err_q;
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_logic_op_ctrl.sv
// Scenario-driven bench for logic_op_ctrl with a transaction-level reference model.
module tb_logic_op_ctrl;

  localparam int W     = 32;
  localparam int RW    = 67;
  localparam int TB_CW = 8;   // narrower counter so the wrap is reached in a few hundred ops

  logic              clk = 1'b0;
  logic              rst_b;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [W-1:0]      a, b;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     result;
  logic              zero, neg, err;
  logic [TB_CW-1:0]  op_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  logic_op_ctrl #(.W(W), .RW(RW), .CW(TB_CW)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .neg(neg), .err(err),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  // Reference: what the consumer should see for one request.
  function automatic logic [RW-1:0] model_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] v;
    case (o)
      2'b00:   v = x & y;
      2'b01:   v = x | y;
      2'b10:   v = x ^ y;
      default: v = '0;
    endcase
    return RW'(v);
  endfunction

  // One full transaction; inputs driven and outputs sampled on the falling edge.
  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int stall);
    logic [RW-1:0] er;
    logic          ez, en, ee;
    er = model_result(o, x, y);
    ez = (er[W-1:0] == '0);
    en = er[W-1];
    ee = (o == 2'b11);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL %s in_ready_idle got=%b exp=1", name, in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y; op = ~o;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL %s exec_handshake got ov=%b ir=%b exp ov=0 ir=0", name, out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL %s latency got out_valid=%b exp=1", name, out_valid); end
    n_checks++;
    if (result !== er || zero !== ez || neg !== en || err !== ee) begin
      n_errors++;
      $display("FAIL %s result got=%h z=%b n=%b e=%b exp=%h z=%b n=%b e=%b",
               name, result, zero, neg, err, er, ez, en, ee);
    end
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom; op = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || op_cnt !== TB_CW'(exp_cnt)) begin
        n_errors++;
        $display("FAIL %s stall%0d got ov=%b ir=%b res=%h cnt=%0d exp ov=1 ir=0 res=%h cnt=%0d",
                 name, i, out_valid, in_ready, result, op_cnt, er, exp_cnt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << TB_CW);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_cnt !== TB_CW'(exp_cnt)) begin
      n_errors++;
      $display("FAIL %s transfer got ov=%b ir=%b cnt=%0d exp ov=0 ir=1 cnt=%0d",
               name, out_valid, in_ready, op_cnt, exp_cnt);
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst_b = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    apply_reset(2);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || op_cnt !== '0 ||
        zero !== 1'b0 || neg !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset got ir=%b ov=%b res=%h cnt=%0d z=%b n=%b e=%b exp ir=1 ov=0 res=0 cnt=0 flags=0",
               in_ready, out_valid, result, op_cnt, zero, neg, err);
    end
  endtask

  task automatic test_ops();
    do_op("and", 2'b00, 32'h0000FFFF, 32'hFFFF0000, 0);
    do_op("or",  2'b01, 32'h0000FFFF, 32'hFFFF0000, 0);
    do_op("xor", 2'b10, 32'h0000FFFF, 32'hFFFF0000, 0);
  endtask

  task automatic test_illegal();
    do_op("illegal", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
  endtask

  task automatic test_backpressure();
    do_op("backpressure", 2'b10, 32'h12345678, 32'h0F0F0F0F, 5);
  endtask

  task automatic test_reset_mid();
    // Reset while in EXEC: the pending op must vanish.
    do_op("pre_mid", 2'b01, 32'h1, 32'h2, 0);
    in_valid = 1'b1; op = 2'b01; a = 32'h80000000; b = 32'h0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1; exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_cnt !== '0 || result !== '0) begin
        n_errors++;
        $display("FAIL rst_exec%0d got ov=%b ir=%b cnt=%0d res=%h exp ov=0 ir=1 cnt=0 res=0",
                 i, out_valid, in_ready, op_cnt, result);
      end
    end
    // Reset while in HOLD, with out_ready high: reset must dominate.
    in_valid = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hF0000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_hold_pre got ov=%b exp=1", out_valid); end
    rst_b = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_cnt !== '0 || result !== '0 || neg !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_hold got ov=%b ir=%b cnt=%0d res=%h n=%b exp ov=0 ir=1 cnt=0 res=0 n=0",
               out_valid, in_ready, op_cnt, result, neg);
    end
    do_op("post_reset", 2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_op("random", 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
  endtask

  task automatic test_wrap();
    apply_reset(1);
    for (int i = 0; i < (1 << TB_CW) - 1; i++)
      do_op("wrap_fill", 2'($urandom_range(0, 2)), $urandom, $urandom, 0);
    n_checks++;
    if (op_cnt !== {TB_CW{1'b1}}) begin
      n_errors++; $display("FAIL wrap_max got=%0d exp=%0d", op_cnt, (1 << TB_CW) - 1);
    end
    do_op("wrap_edge", 2'b01, 32'h0, 32'h0, 0);
    n_checks++;
    if (op_cnt !== '0) begin n_errors++; $display("FAIL wrap_zero got=%0d exp=0", op_cnt); end
  endtask

  initial begin
    rst_b = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_ops();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
